// File: rtl/d_bus_wb_pkg.sv
// Shared types and constants for the core-to-Wishbone data master.
package d_bus_wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUS   = 2'd1,
    ST_RETRY = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    HW_SWP   = 2'b00,
    HW_UHALF = 2'b01,
    HW_SBYTE = 2'b10,
    HW_SHALF = 2'b11
  } hw_type_e;

  typedef struct packed {
    logic     rw;
    logic     bw;
    logic     hw_xfer;
    hw_type_e hw_type;
  } access_attr_t;

  localparam logic [3:0] SEL_WORD    = 4'b1111;
  localparam logic [3:0] SEL_HALF_LO = 4'b0011;
  localparam logic [3:0] SEL_HALF_HI = 4'b1100;
  localparam logic [3:0] SEL_BYTE0   = 4'b0001;

endpackage

// File: rtl/d_bus_lane_steer.sv
// Combinational byte-lane steering: selects, replicated write data, extended read data.
module d_bus_lane_steer
  import d_bus_wb_pkg::*;
#(
  parameter int unsigned DW = 32
) (
  input  logic [$clog2(DW/8)-1:0] addr_lo,
  input  access_attr_t            attr,
  input  logic [31:0]             core_wdata,
  input  logic [DW-1:0]           bus_rdata,
  output logic [DW/8-1:0]         sel_c,
  output logic [DW-1:0]           wdata_c,
  output logic [31:0]             rdata_c,
  output logic                    misaligned_c
);

  logic        is_half;
  logic        is_byte;
  logic        is_signed;
  logic [1:0]  lane;
  logic [3:0]  lane_sel;
  logic [31:0] word_wd;
  logic [31:0] word_rd;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [63:0] word_dbl;

  // Access kind and 32-bit lane pattern
  always_comb begin
    lane      = addr_lo[1:0];
    is_half   = attr.hw_xfer && (attr.hw_type == HW_UHALF || attr.hw_type == HW_SHALF);
    is_byte   = attr.hw_xfer ? (attr.hw_type == HW_SBYTE || (attr.hw_type == HW_SWP && attr.bw))
                             : attr.bw;
    is_signed = attr.hw_xfer && (attr.hw_type == HW_SBYTE || attr.hw_type == HW_SHALF);
    misaligned_c = is_half && addr_lo[0];

    lane_sel = SEL_WORD;
    word_wd  = core_wdata;
    if (is_half) begin
      lane_sel = addr_lo[1] ? SEL_HALF_HI : SEL_HALF_LO;
      word_wd  = {2{core_wdata[15:0]}};
    end else if (is_byte) begin
      lane_sel = SEL_BYTE0 << lane;
      word_wd  = {4{core_wdata[7:0]}};
    end

    byte_val = word_rd[{lane, 3'b000} +: 8];
    half_val = addr_lo[1] ? word_rd[31:16] : word_rd[15:0];
    word_dbl = {word_rd, word_rd};
    if (is_half)
      rdata_c = is_signed ? {{16{half_val[15]}}, half_val} : {16'h0000, half_val};
    else if (is_byte)
      rdata_c = is_signed ? {{24{byte_val[7]}}, byte_val} : {24'h000000, byte_val};
    else
      rdata_c = word_dbl[{lane, 3'b000} +: 32];
  end

  // Placement of the 32-bit pattern onto the bus width
  if (DW == 64) begin : g_dw64
    always_comb begin
      sel_c   = addr_lo[2] ? {lane_sel, 4'b0000} : {4'b0000, lane_sel};
      wdata_c = addr_lo[2] ? {word_wd, 32'h0} : {32'h0, word_wd};
      word_rd = addr_lo[2] ? bus_rdata[63:32] : bus_rdata[31:0];
    end
  end else begin : g_dw32
    always_comb begin
      sel_c   = lane_sel;
      wdata_c = word_wd;
      word_rd = bus_rdata;
    end
  end

endmodule

// File: rtl/d_bus_wb_master.sv
// Registered Wishbone master for the core data-memory port: retry, timeout, abort, lane steering.
module d_bus_wb_master
  import d_bus_wb_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned DW        = 32,
  parameter int unsigned RETRY_MAX = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [AW-1:0]   in_MEMAccessAddress,
  input  logic            in_MEMAccessRequest,
  input  logic            in_MEMAccessRW,
  input  logic            in_MEMAccessBW,
  input  logic            in_MEMAccessHalfWordTransfer,
  input  logic [1:0]      in_MEMAccessHalfWordType,
  input  logic [31:0]     in_DataCacheBus,
  output logic [31:0]     out_DataCacheBus,
  output logic            out_DataCacheWait,
  output logic            out_DataAbort,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_data_o,
  input  logic [DW-1:0]   wb_data_i,
  output logic [DW/8-1:0] wb_sel_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_rty_i
);

  localparam int unsigned OB = $clog2(DW/8);
  localparam int unsigned RW = $clog2(RETRY_MAX + 2);
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  state_e          state_q, state_d;
  access_attr_t    attr_q, attr_d, attr_in, attr_cur;
  logic [OB-1:0]   lo_q, lo_d, lo_cur;
  logic [RW-1:0]   retry_q, retry_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [31:0]     rdata_d;
  logic            abort_d;
  logic [AW-1:0]   addr_d;
  logic [DW-1:0]   wdata_d;
  logic [DW/8-1:0] sel_d;
  logic            cyc_d, stb_d, we_d;
  logic            tmo_hit;
  logic [DW/8-1:0] sel_c;
  logic [DW-1:0]   wdata_c;
  logic [31:0]     rdata_c;
  logic            misaligned_c;

  // Steering sees live core attributes while idle, latched ones during the access
  always_comb begin
    attr_in.rw      = in_MEMAccessRW;
    attr_in.bw      = in_MEMAccessBW;
    attr_in.hw_xfer = in_MEMAccessHalfWordTransfer;
    attr_in.hw_type = hw_type_e'(in_MEMAccessHalfWordType);
    attr_cur        = (state_q == ST_IDLE) ? attr_in : attr_q;
    lo_cur          = (state_q == ST_IDLE) ? in_MEMAccessAddress[OB-1:0] : lo_q;
  end

  d_bus_lane_steer #(.DW(DW)) u_steer (
    .addr_lo      (lo_cur),
    .attr         (attr_cur),
    .core_wdata   (in_DataCacheBus),
    .bus_rdata    (wb_data_i),
    .sel_c        (sel_c),
    .wdata_c      (wdata_c),
    .rdata_c      (rdata_c),
    .misaligned_c (misaligned_c)
  );

  assign out_DataCacheWait = in_MEMAccessRequest && (state_q != ST_DONE);
  assign tmo_hit = (TIMEOUT != 0) && ((32'(tmo_q) + 32'd1) >= TIMEOUT);

  // Next state and next register values
  always_comb begin
    state_d = state_q;
    attr_d  = attr_q;
    lo_d    = lo_q;
    retry_d = retry_q;
    tmo_d   = tmo_q;
    rdata_d = out_DataCacheBus;
    abort_d = out_DataAbort;
    addr_d  = wb_addr_o;
    wdata_d = wb_data_o;
    sel_d   = wb_sel_o;
    cyc_d   = wb_cyc_o;
    stb_d   = wb_stb_o;
    we_d    = wb_we_o;

    case (state_q)
      ST_IDLE: begin
        if (in_MEMAccessRequest) begin
          attr_d  = attr_in;
          lo_d    = in_MEMAccessAddress[OB-1:0];
          retry_d = '0;
          tmo_d   = '0;
          if (misaligned_c) begin
            state_d = ST_DONE;
            abort_d = 1'b1;
            rdata_d = 32'h0;
          end else begin
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            stb_d   = 1'b1;
            we_d    = ~in_MEMAccessRW;
            addr_d  = {in_MEMAccessAddress[AW-1:OB], OB'(0)};
            sel_d   = sel_c;
            wdata_d = wdata_c;
          end
        end
      end
      ST_BUS: begin
        if (wb_err_i) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          abort_d = 1'b1;
          rdata_d = 32'h0;
        end else if (wb_ack_i) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          abort_d = 1'b0;
          rdata_d = attr_q.rw ? rdata_c : 32'h0;
        end else if (wb_rty_i) begin
          state_d = ST_RETRY;
          stb_d   = 1'b0;
          retry_d = (retry_q == '1) ? retry_q : retry_q + RW'(1);
        end else if (tmo_hit) begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          abort_d = 1'b1;
          rdata_d = 32'h0;
        end else begin
          tmo_d = (tmo_q == '1) ? tmo_q : tmo_q + TW'(1);
        end
      end
      ST_RETRY: begin
        if (32'(retry_q) <= RETRY_MAX) begin
          state_d = ST_BUS;
          stb_d   = 1'b1;
          tmo_d   = '0;
        end else begin
          state_d = ST_DONE;
          cyc_d   = 1'b0;
          abort_d = 1'b1;
          rdata_d = 32'h0;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset drops the bus cycle immediately
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q          <= ST_IDLE;
      attr_q           <= '0;
      lo_q             <= '0;
      retry_q          <= '0;
      tmo_q            <= '0;
      out_DataCacheBus <= '0;
      out_DataAbort    <= 1'b0;
      wb_addr_o        <= '0;
      wb_data_o        <= '0;
      wb_sel_o         <= '0;
      wb_cyc_o         <= 1'b0;
      wb_stb_o         <= 1'b0;
      wb_we_o          <= 1'b0;
    end else begin
      state_q          <= state_d;
      attr_q           <= attr_d;
      lo_q             <= lo_d;
      retry_q          <= retry_d;
      tmo_q            <= tmo_d;
      out_DataCacheBus <= rdata_d;
      out_DataAbort    <= abort_d;
      wb_addr_o        <= addr_d;
      wb_data_o        <= wdata_d;
      wb_sel_o         <= sel_d;
      wb_cyc_o         <= cyc_d;
      wb_stb_o         <= stb_d;
      wb_we_o          <= we_d;
    end
  end

endmodule

// File: tb/tb_d_bus_wb_master.sv
// Bench for d_bus_wb_master: 32- and 64-bit instances driven in lockstep against a transaction model.
module tb_d_bus_wb_master;

  localparam int unsigned RMAX = 4;
  localparam int unsigned TMO  = 12;
  localparam int R_NONE = 0, R_ACK = 1, R_RTY = 2, R_ERR = 3, R_EA = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr, cwd;
  logic        req, rw, bw, hwx;
  logic [1:0]  hwt;
  logic        ack, err, rty;
  logic [31:0] di32;
  logic [63:0] di64;

  logic [31:0] rd32, rd64, wa32, wa64, wd32;
  logic [63:0] wd64;
  logic        wt32, wt64, ab32, ab64, cyc32, cyc64, stb32, stb64, we32, we64;
  logic [3:0]  sel32;
  logic [7:0]  sel64;

  int errors = 0;
  int checks = 0;

  logic        e_chk = 1'b0, e_cyc, e_stb, e_done, e_wait, e_we, e_abort;
  logic [31:0] e_addr32, e_addr64, e_wd32, e_rd;
  logic [63:0] e_wd64;
  logic [3:0]  e_sel32;
  logic [7:0]  e_sel64;
  logic [31:0] l_rd, l_wd, l_addr;
  logic [3:0]  l_sel32;
  logic [7:0]  l_sel64;
  logic        l_abort, l_we;
  int script[$];

  always #5 clk = ~clk;

  d_bus_wb_master #(.AW(32), .DW(32), .RETRY_MAX(RMAX), .TIMEOUT(TMO)) dut32 (
    .clk_i(clk), .rst_i(rst), .in_MEMAccessAddress(addr), .in_MEMAccessRequest(req),
    .in_MEMAccessRW(rw), .in_MEMAccessBW(bw), .in_MEMAccessHalfWordTransfer(hwx),
    .in_MEMAccessHalfWordType(hwt), .in_DataCacheBus(cwd), .out_DataCacheBus(rd32),
    .out_DataCacheWait(wt32), .out_DataAbort(ab32), .wb_addr_o(wa32), .wb_data_o(wd32),
    .wb_data_i(di32), .wb_sel_o(sel32), .wb_cyc_o(cyc32), .wb_stb_o(stb32), .wb_we_o(we32),
    .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty));

  d_bus_wb_master #(.AW(32), .DW(64), .RETRY_MAX(RMAX), .TIMEOUT(TMO)) dut64 (
    .clk_i(clk), .rst_i(rst), .in_MEMAccessAddress(addr), .in_MEMAccessRequest(req),
    .in_MEMAccessRW(rw), .in_MEMAccessBW(bw), .in_MEMAccessHalfWordTransfer(hwx),
    .in_MEMAccessHalfWordType(hwt), .in_DataCacheBus(cwd), .out_DataCacheBus(rd64),
    .out_DataCacheWait(wt64), .out_DataAbort(ab64), .wb_addr_o(wa64), .wb_data_o(wd64),
    .wb_data_i(di64), .wb_sel_o(sel64), .wb_cyc_o(cyc64), .wb_stb_o(stb64), .wb_we_o(we64),
    .wb_ack_i(ack), .wb_err_i(err), .wb_rty_i(rty));

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Access-size classification from the core attributes: 0 word, 1 byte, 2 half
  function automatic int m_kind(input logic b, input logic x, input logic [1:0] t);
    if (x && (t == 2'd1 || t == 2'd3)) return 2;
    if (x && t == 2'd2) return 1;
    return b ? 1 : 0;
  endfunction

  function automatic logic [3:0] m_sel(input logic [31:0] a, input int k);
    if (k == 2) return (a % 4 >= 2) ? 4'hC : 4'h3;
    if (k == 1) return 4'(1 << (a % 4));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wd(input logic [31:0] d, input int k);
    if (k == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (k == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] m_rd(input logic [31:0] a, input int k, input logic sgn,
                                       input logic [31:0] w);
    logic [63:0] v;
    int sh;
    if (k == 1) begin
      v = 64'((w >> (8 * (a % 4))) & 32'hFF);
      if (sgn && v >= 64'h80) v = v + 64'hFFFF_FF00;
    end else if (k == 2) begin
      v = 64'((w >> (16 * ((a % 4) / 2))) & 32'hFFFF);
      if (sgn && v >= 64'h8000) v = v + 64'hFFFF_0000;
    end else begin
      sh = 8 * int'(a % 4);
      v  = ({32'h0, w} >> sh) | ({32'h0, w} << (32 - sh));
    end
    return v[31:0];
  endfunction

  // Per-cycle comparison of both instances against the model expectations
  always @(negedge clk) begin
    if (e_chk) begin
      check("cyc32", cyc32, e_cyc);   check("cyc64", cyc64, e_cyc);
      check("stb32", stb32, e_stb);   check("stb64", stb64, e_stb);
      check("wait32", wt32, e_wait);  check("wait64", wt64, e_wait);
      if (e_cyc) begin
        check("addr32", wa32, e_addr32); check("addr64", wa64, e_addr64);
        check("sel32", sel32, e_sel32);  check("sel64", sel64, e_sel64);
        check("we32", we32, e_we);       check("we64", we64, e_we);
        if (e_we) begin
          check("wdo32", wd32, e_wd32);  check("wdo64", wd64, e_wd64);
        end
      end
      if (e_done) begin
        check("rdata32", rd32, e_rd);    check("rdata64", rd64, e_rd);
        check("abort32", ab32, e_abort); check("abort64", ab64, e_abort);
      end
    end
  end

  task automatic cyc_step(input logic c, input logic s, input logic d);
    e_cyc = c; e_stb = s; e_done = d; e_wait = req && !d; e_chk = 1'b1;
    @(negedge clk);
    if (c && s) begin
      l_sel32 = sel32; l_sel64 = sel64; l_wd = wd32; l_addr = wa32; l_we = we32;
    end
    if (d) begin
      l_rd = rd32; l_abort = ab32;
    end
    @(posedge clk); #1;
  endtask

  // One core access; bus responses come from 'script', one entry per BUS cycle
  task automatic txn(input logic [31:0] a, input logic r, input logic b, input logic x,
                     input logic [1:0] t, input logic [31:0] d, input logic [31:0] w, input bit gap);
    int k, idx, retries, tmo, resp;
    bit fin, abrt;
    logic [3:0] ls;
    k = m_kind(b, x, t);
    ls = m_sel(a, k);
    addr = a; req = 1'b1; rw = r; bw = b; hwx = x; hwt = t; cwd = d;
    di32 = w; di64 = a[2] ? {w, ~w} : {~w, w};
    e_addr32 = a & ~32'd3; e_addr64 = a & ~32'd7; e_we = !r;
    e_sel32 = ls; e_sel64 = a[2] ? {ls, 4'h0} : {4'h0, ls};
    e_wd32 = m_wd(d, k); e_wd64 = a[2] ? {m_wd(d, k), 32'h0} : {32'h0, m_wd(d, k)};
    cyc_step(1'b0, 1'b0, 1'b0);
    abrt = 1'b1;
    if (!(k == 2 && a[0])) begin
      idx = 0; retries = 0; tmo = 0; fin = 1'b0;
      while (!fin) begin
        resp = (idx < script.size()) ? script[idx] : R_NONE;
        idx++;
        ack = (resp == R_ACK || resp == R_EA);
        err = (resp == R_ERR || resp == R_EA);
        rty = (resp == R_RTY);
        cyc_step(1'b1, 1'b1, 1'b0);
        ack = 1'b0; err = 1'b0; rty = 1'b0;
        if (resp == R_ERR || resp == R_EA) begin
          fin = 1'b1;
        end else if (resp == R_ACK) begin
          fin = 1'b1; abrt = 1'b0;
        end else if (resp == R_RTY) begin
          retries++; tmo = 0;
          cyc_step(1'b1, 1'b0, 1'b0);
          if (retries > int'(RMAX)) fin = 1'b1;
        end else begin
          tmo++;
          if (tmo == int'(TMO)) fin = 1'b1;
        end
      end
    end
    e_abort = abrt;
    e_rd = (!abrt && r) ? m_rd(a, k, x && t[1], w) : 32'h0;
    cyc_step(1'b0, 1'b0, 1'b1);
    script.delete();
    if (gap) begin
      req = 1'b0;
      cyc_step(1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; rw = 1'b0; bw = 1'b0; hwx = 1'b0; hwt = 2'd0;
    cwd = '0; ack = 1'b0; err = 1'b0; rty = 1'b0; di32 = '0; di64 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_cyc", {cyc32, cyc64, stb32, stb64, we32, we64}, 6'b0);
    check("rst_bus", {wa32, wa64, wd32}, 96'h0);
    check("rst_sel", {sel32, sel64, wd64}, 76'h0);
    check("rst_out", {rd32, rd64, ab32, ab64}, 66'h0);
    @(posedge clk); #1;

    check("model_sbyte", m_rd(32'h103, 1, 1'b1, 32'h80FF_FFFF), 32'hFFFF_FF80);
    check("model_rot", m_rd(32'h101, 0, 1'b0, 32'h1122_3344), 32'h4411_2233);

    script = '{R_ACK};
    txn(32'h100, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h1122_3344, 1'b1);
    check("t1_rdata", l_rd, 32'h1122_3344);
    check("t1_abort", l_abort, 1'b0);

    script = '{R_ACK};
    txn(32'h103, 1'b1, 1'b0, 1'b1, 2'b10, 32'h0, 32'h80FF_FFFF, 1'b1);
    check("t2_sel32", l_sel32, 4'b1000);
    check("t2_rdata", l_rd, 32'hFFFF_FF80);
    script = '{R_ACK};
    txn(32'h107, 1'b1, 1'b0, 1'b1, 2'b10, 32'h0, 32'h80FF_FFFF, 1'b1);
    check("t2_sel64", l_sel64, 8'h80);

    script = '{R_ACK};
    txn(32'h101, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0000_0042, 32'h0, 1'b1);
    check("t3_we", l_we, 1'b1);
    check("t3_sel", l_sel32, 4'b0010);
    check("t3_wdata", l_wd, 32'h4242_4242);
    check("t3_addr", l_addr, 32'h100);

    script = '{R_RTY, R_RTY, R_ACK};
    txn(32'h104, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'hCAFE_F00D, 1'b1);
    check("t4_abort", l_abort, 1'b0);
    script = '{R_RTY, R_RTY, R_RTY, R_RTY, R_RTY};
    txn(32'h108, 1'b0, 1'b0, 1'b0, 2'd0, 32'h1234_5678, 32'h0, 1'b1);
    check("t4_abort_max", l_abort, 1'b1);

    script = '{R_EA};
    txn(32'h10C, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'hDEAD_BEEF, 1'b1);
    check("t5_err_rdata", l_rd, 32'h0);
    txn(32'h110, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h5555_AAAA, 1'b1);
    check("t5_tmo_abort", l_abort, 1'b1);

    txn(32'h101, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h1111_2222, 1'b1);
    check("t6_misalign", l_abort, 1'b1);

    script = '{R_ACK};
    txn(32'h102, 1'b1, 1'b0, 1'b1, 2'b01, 32'h0, 32'h8765_4321, 1'b1);
    check("uhalf_rdata", l_rd, 32'h0000_8765);
    script = '{R_ACK};
    txn(32'h106, 1'b1, 1'b0, 1'b1, 2'b11, 32'h0, 32'h8000_1234, 1'b0);
    check("shalf_rdata", l_rd, 32'hFFFF_8000);
    script = '{R_ACK};
    txn(32'h101, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h1122_3344, 1'b0);
    check("rot_rdata", l_rd, 32'h4411_2233);
    script = '{R_ACK};
    txn(32'h106, 1'b0, 1'b0, 1'b1, 2'b01, 32'h0000_BEEF, 32'h0, 1'b1);
    check("half_wdata", l_wd, 32'hBEEF_BEEF);
    script = '{R_ACK};
    txn(32'h102, 1'b1, 1'b1, 1'b1, 2'b00, 32'h0, 32'h00A5_0000, 1'b1);
    check("swp_byte", l_rd, 32'h0000_00A5);

    // Reset in the middle of a bus cycle
    e_chk = 1'b0;
    addr = 32'h200; req = 1'b1; rw = 1'b1; bw = 1'b0; hwx = 1'b0; hwt = 2'd0;
    @(posedge clk); #2;
    check("mid_cyc_before", {cyc32, cyc64}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_cyc", {cyc32, cyc64, stb32, stb64}, 4'b0);
    req = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_idle", {wt32, wt64, cyc32, cyc64}, 4'b0);
    script = '{R_ACK};
    txn(32'h204, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0BAD_C0DE, 1'b1);
    check("post_rst_rdata", l_rd, 32'h0BAD_C0DE);

    e_chk = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
